io_responder: RTL and testbench

- Memory-mapped IO target that answers the core's IO port (IO_mem_addr / IO_mem_wdata / IO_mem_wr out, IO_mem_rdata in).
- Sits in the SoC beside the core. Provides three registers: an LED output register, a UART transmit data register and a UART status register.
- Contains a baud-timed UART transmitter state machine: 8N1, LSB first.

---
 rtl/io_responder_pkg.sv | 32 +++
 rtl/io_responder_if.sv | 22 ++
 rtl/io_responder_uart_tx.sv | 161 ++++++++++++++++
 rtl/io_responder.sv | 75 +++++++
 tb/tb_io_responder.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/io_responder_pkg.sv
// Shared definitions for io_responder: register word indices, byte addresses,
// status bit positions and the UART transmitter state encoding.
package io_pkg;

  localparam int LED_W_IDX     = 0;
  localparam int UART_DATA_IDX = 1;
  localparam int UART_STAT_IDX = 2;
  localparam int N_SEL         = 3;

  localparam int STAT_BUSY_BIT   = 9;
  localparam int STAT_ACTIVE_BIT = 8;

  localparam logic [31:0] ADDR_LED       = 32'h0040_0004;
  localparam logic [31:0] ADDR_UART_DATA = 32'h0040_0008;
  localparam logic [31:0] ADDR_UART_STAT = 32'h0040_0010;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_t;

  function automatic logic [31:0] status_word(input logic busy, input logic active);
    logic [31:0] w;
    w                  = '0;
    w[STAT_BUSY_BIT]   = busy;
    w[STAT_ACTIVE_BIT] = active;
    return w;
  endfunction

endpackage

// File: rtl/io_responder_if.sv
// Core-side IO port bundle: the core drives address/data/strobe (master),
// the IO target answers with combinational read data (slave).
interface io_responder_if;
  logic [31:0] IO_mem_addr;
  logic [31:0] IO_mem_wdata;
  logic        IO_mem_wr;
  logic [31:0] IO_mem_rdata;

  modport master (
    output IO_mem_addr,
    output IO_mem_wdata,
    output IO_mem_wr,
    input  IO_mem_rdata
  );

  modport slave (
    input  IO_mem_addr,
    input  IO_mem_wdata,
    input  IO_mem_wr,
    output IO_mem_rdata
  );
endinterface

// File: rtl/io_responder_uart_tx.sv
// 8N1 LSB-first UART transmitter with baud counter. Defining IO_TXFIFO_EN puts
// a 4-entry FIFO in front of the FSM; otherwise the shift register is the only buffer.
module uart_tx
  import io_pkg::*;
#(
  parameter int BAUD_DIV = 10
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [7:0] data,
  input  logic       valid,
  output logic       busy,
  output logic       active,
  output logic       tx
);

  localparam int                BCNT_W    = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
  localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(BAUD_DIV - 1);

  tx_state_t         r_state, w_state_next;
  logic [BCNT_W-1:0] r_bcnt, w_bcnt_next;
  logic [2:0]        r_idx, w_idx_next;
  logic [7:0]        r_shift, w_shift_next;
  logic              r_tx, w_tx_next;

  logic              w_load;
  logic [7:0]        w_load_data;

`ifdef IO_TXFIFO_EN
  logic [7:0] r_fifo [4];
  logic [1:0] r_wr_ptr;
  logic [1:0] r_rd_ptr;
  logic [2:0] r_count, w_count_next;
  logic       w_push;
  logic       w_pop;

  // A full FIFO refuses the push even when the FSM pops in the same cycle.
  assign w_push      = valid && (r_count != 3'd4);
  assign w_pop       = (r_state == TX_IDLE) && (r_count != 3'd0);
  assign w_load      = w_pop;
  assign w_load_data = r_fifo[r_rd_ptr];
  assign busy        = (r_count == 3'd4);
  assign active      = (r_state != TX_IDLE) || (r_count != 3'd0);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo[r_wr_ptr] <= data;
    end
  end

  always_comb begin
    w_count_next = r_count;
    if (w_push && !w_pop) begin
      w_count_next = r_count + 3'd1;
    end else if (!w_push && w_pop) begin
      w_count_next = r_count - 3'd1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 2'd1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 2'd1;
      end
      r_count <= w_count_next;
    end
  end
`else
  // Without a FIFO a byte is taken only while the line is idle.
  assign w_load      = valid && (r_state == TX_IDLE);
  assign w_load_data = data;
  assign busy        = (r_state != TX_IDLE);
  assign active      = (r_state != TX_IDLE);
`endif

  always_comb begin
    w_state_next = r_state;
    w_bcnt_next  = r_bcnt;
    w_idx_next   = r_idx;
    w_shift_next = r_shift;
    unique case (r_state)
      TX_IDLE: begin
        if (w_load) begin
          w_state_next = TX_START;
          w_bcnt_next  = '0;
          w_idx_next   = '0;
          w_shift_next = w_load_data;
        end
      end
      TX_START: begin
        if (r_bcnt == BCNT_LAST) begin
          w_state_next = TX_DATA;
          w_bcnt_next  = '0;
          w_idx_next   = '0;
        end else begin
          w_bcnt_next = r_bcnt + BCNT_W'(1);
        end
      end
      TX_DATA: begin
        if (r_bcnt == BCNT_LAST) begin
          w_bcnt_next  = '0;
          w_shift_next = {1'b0, r_shift[7:1]};
          if (r_idx == 3'd7) begin
            w_state_next = TX_STOP;
          end else begin
            w_idx_next = r_idx + 3'd1;
          end
        end else begin
          w_bcnt_next = r_bcnt + BCNT_W'(1);
        end
      end
      TX_STOP: begin
        if (r_bcnt == BCNT_LAST) begin
          w_state_next = TX_IDLE;
          w_bcnt_next  = '0;
        end else begin
          w_bcnt_next = r_bcnt + BCNT_W'(1);
        end
      end
      default: begin
        w_state_next = TX_IDLE;
      end
    endcase
  end

  // The line level is registered from the next state so UART_TX never glitches.
  always_comb begin
    w_tx_next = 1'b1;
    unique case (w_state_next)
      TX_START: w_tx_next = 1'b0;
      TX_DATA:  w_tx_next = w_shift_next[0];
      default:  w_tx_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= TX_IDLE;
      r_bcnt  <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
    end else begin
      r_state <= w_state_next;
      r_bcnt  <= w_bcnt_next;
      r_idx   <= w_idx_next;
      r_shift <= w_shift_next;
      r_tx    <= w_tx_next;
    end
  end

  assign tx = r_tx;

endmodule

// File: rtl/io_responder.sv
// Memory-mapped IO target: LED register, UART data and status registers.
// Build with IO_TXFIFO_EN defined to add a 4-entry TX FIFO inside uart_tx.
module io_responder
  import io_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 10_000_000,
  parameter int BAUD_RATE   = 1_000_000,
  parameter int LED_W       = 6
) (
  input  logic             clk,
  input  logic             resetn,
  io_responder_if.slave    io_bus,
  output logic [LED_W-1:0] LEDS,
  output logic             UART_TX
);

  localparam int BAUD_DIV = CLK_FREQ_HZ / BAUD_RATE;

  if (BAUD_DIV < 2) begin : g_bad_baud
    $error("io_responder: CLK_FREQ_HZ/BAUD_RATE must be at least 2");
  end

  logic [N_SEL-1:0] w_sel;
  logic [LED_W-1:0] r_leds;
  logic             w_uart_busy;
  logic             w_uart_active;
  logic             w_uart_valid;
  logic [31:0]      w_rdata;
  logic             w_unused_bits;

  // Word select is the one-hot word index addr[15:2]; only the low three bits map to registers.
  genvar gi;
  for (gi = 0; gi < N_SEL; gi++) begin : g_sel
    assign w_sel[gi] = io_bus.IO_mem_addr[gi + 2];
  end

  assign w_unused_bits = ^{io_bus.IO_mem_addr[31:N_SEL+2], io_bus.IO_mem_addr[1:0],
                           io_bus.IO_mem_wdata};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_leds <= '0;
    end else if (io_bus.IO_mem_wr && w_sel[LED_W_IDX]) begin
      r_leds <= io_bus.IO_mem_wdata[LED_W-1:0];
    end
  end

  assign w_uart_valid = io_bus.IO_mem_wr && w_sel[UART_DATA_IDX];

  uart_tx #(
    .BAUD_DIV (BAUD_DIV)
  ) u_uart_tx (
    .clk    (clk),
    .resetn (resetn),
    .data   (io_bus.IO_mem_wdata[7:0]),
    .valid  (w_uart_valid),
    .busy   (w_uart_busy),
    .active (w_uart_active),
    .tx     (UART_TX)
  );

  // The core samples read data in the same cycle it presents the address.
  always_comb begin
    w_rdata = '0;
    if (w_sel[UART_STAT_IDX]) begin
      w_rdata = status_word(w_uart_busy, w_uart_active);
    end else if (w_sel[LED_W_IDX]) begin
      w_rdata = 32'(r_leds);
    end
  end

  assign io_bus.IO_mem_rdata = w_rdata;
  assign LEDS                = r_leds;

endmodule

// File: tb/tb_io_responder.sv
// Self-checking bench for io_responder: register accesses are checked inline,
// UART frames are decoded by a monitor and matched against a queue of expected bytes.
module tb_io_responder;
  import io_pkg::*;

  localparam int BD = 10;
`ifdef IO_TXFIFO_EN
  localparam int          LAT     = 1;
  localparam logic [31:0] ST_BUSY = 32'h100;
`else
  localparam int          LAT     = 0;
  localparam logic [31:0] ST_BUSY = 32'h300;
`endif

  typedef struct {
    logic [7:0] data;
    int         start;
  } frame_t;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic [5:0] leds;
  logic       uart_tx;
  int         cyc = 0;
  int         n_checks = 0;
  int         n_pass = 0;
  frame_t     exp_q[$];

  io_responder_if bus ();

  io_responder #(
    .CLK_FREQ_HZ (10_000_000),
    .BAUD_RATE   (1_000_000),
    .LED_W       (6)
  ) dut (
    .clk     (clk),
    .resetn  (resetn),
    .io_bus  (bus.slave),
    .LEDS    (leds),
    .UART_TX (uart_tx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
  endtask

  // Called at a negedge; returns at the next negedge with the capture cycle number.
  task automatic bus_write(input logic [31:0] a, input logic [31:0] d, output int c);
    bus.IO_mem_addr  = a;
    bus.IO_mem_wdata = d;
    bus.IO_mem_wr    = 1'b1;
    @(negedge clk);
    c = cyc;
    bus.IO_mem_wr = 1'b0;
    $display("write addr 0x%08h data 0x%08h captured at cycle %0d", a, d, c);
  endtask

  task automatic read_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
    bus.IO_mem_addr = a;
    #1;
    chk(name, bus.IO_mem_rdata, exp);
  endtask

  task automatic idle_to(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic expect_frame(input logic [7:0] d, input int s);
    frame_t f;
    f.data  = d;
    f.start = s;
    exp_q.push_back(f);
  endtask

  // UART monitor: every cycle of every bit must hold the level of that bit's first cycle.
  initial begin
    int         st;
    logic [9:0] bits;
    bit         stable;
    bit         aborted;
    logic       bv;
    frame_t     e;
    forever begin
      @(negedge clk);
      if (resetn && uart_tx === 1'b0) begin
        st      = cyc;
        stable  = 1'b1;
        aborted = 1'b0;
        bits    = '0;
        for (int b = 0; b < 10; b++) begin
          if (b > 0) @(negedge clk);
          if (!resetn) begin aborted = 1'b1; break; end
          bv      = uart_tx;
          bits[b] = bv;
          for (int k = 1; k < BD; k++) begin
            @(negedge clk);
            if (!resetn) begin aborted = 1'b1; break; end
            if (uart_tx !== bv) stable = 1'b0;
          end
          if (aborted) break;
        end
        if (!aborted) begin
          $display("frame byte 0x%02h start cycle %0d", bits[8:1], st);
          if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL uart_unexpected_frame: got byte 0x%02h at cycle %0d, expected none",
                     bits[8:1], st);
          end else begin
            e = exp_q.pop_front();
            chk("uart_data", 32'(bits[8:1]), 32'(e.data));
            chk("uart_start_cycle", 32'(st), 32'(e.start));
            chk("uart_stop_bit", 32'(bits[9]), 32'd1);
            chk("uart_bit_timing", 32'(stable), 32'd1);
          end
        end
      end
    end
  end

  initial begin
    int p;
    int q;
    bus.IO_mem_addr  = '0;
    bus.IO_mem_wdata = '0;
    bus.IO_mem_wr    = 1'b0;
    resetn           = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_uart_tx", 32'(uart_tx), 32'd1);
    chk("reset_leds", 32'(leds), 32'd0);
    read_chk("reset_status", ADDR_UART_STAT, 32'h0);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);

    bus_write(ADDR_LED, 32'h3F, p);
    chk("led_write", 32'(leds), 32'h3F);
    read_chk("led_read", ADDR_LED, 32'h3F);
    bus_write(ADDR_LED, 32'hFFFF_FFEA, p);
    chk("led_write_trunc", 32'(leds), 32'h2A);
    read_chk("led_read_trunc", ADDR_LED, 32'h2A);
    bus.IO_mem_addr  = ADDR_LED;
    bus.IO_mem_wdata = 32'h0;
    @(negedge clk);
    chk("led_no_wr", 32'(leds), 32'h2A);
    read_chk("uart_data_read_zero", ADDR_UART_DATA, 32'h0);
    read_chk("unmapped_read_zero", 32'h0040_0020, 32'h0);

    // LED + status selected: write lands in LEDS, read returns status.
    bus_write(32'h0040_0014, 32'h15, p);
    chk("multi_led_write", 32'(leds), 32'h15);
    read_chk("multi_read_status_prio", 32'h0040_0014, 32'h0);

    bus_write(ADDR_UART_DATA, 32'h55, p);
    expect_frame(8'h55, p + LAT);
    bus.IO_mem_addr = ADDR_UART_STAT;
    for (int i = 0; i < 100 + LAT; i++) begin
      #1 chk("status_during_frame", bus.IO_mem_rdata, ST_BUSY);
      @(negedge clk);
    end
    #1 chk("status_after_frame", bus.IO_mem_rdata, 32'h0);
    @(negedge clk);

    // LED + UART data selected: both registers take the write.
    bus_write(32'h0040_000C, 32'h07, p);
    expect_frame(8'h07, p + LAT);
    chk("multi_led_uart_leds", 32'(leds), 32'h07);
    read_chk("multi_read_led", 32'h0040_000C, 32'h07);
    idle_to(p + 100 + LAT + 2);

`ifndef IO_TXFIFO_EN
    bus_write(ADDR_UART_DATA, 32'hA5, p);
    expect_frame(8'hA5, p);
    idle_to(p + 50);
    bus_write(ADDR_UART_DATA, 32'h11, q);
    read_chk("status_busy_midframe", ADDR_UART_STAT, 32'h300);
    idle_to(p + 102);

    bus_write(ADDR_UART_DATA, 32'h81, p);
    expect_frame(8'h81, p);
    idle_to(p + 99);
    bus_write(ADDR_UART_DATA, 32'hEE, q);
    bus_write(ADDR_UART_DATA, 32'h42, q);
    expect_frame(8'h42, p + 101);
    idle_to(p + 101 + 102);
`else
    for (int i = 1; i <= 6; i++) begin
      bus_write(ADDR_UART_DATA, 32'(i), q);
      if (i == 1) p = q;
      if (i <= 5) expect_frame(8'(i), p + 1 + (i - 1) * (10 * BD + 1));
      if (i == 5) read_chk("fifo_full_status", ADDR_UART_STAT, 32'h300);
    end
    bus.IO_mem_addr = ADDR_UART_STAT;
    idle_to(p + 101);
    #1 chk("fifo_full_before_pop", bus.IO_mem_rdata, 32'h300);
    @(negedge clk);
    #1 chk("fifo_busy_clear_on_pop", bus.IO_mem_rdata, 32'h100);
    idle_to(p + 1 + 5 * (10 * BD + 1) + 5);
`endif

    // Reset in the middle of a frame aborts it immediately.
    bus_write(ADDR_UART_DATA, 32'h3C, p);
    expect_frame(8'h3C, p + LAT);
    idle_to(p + 35 + LAT);
    bus.IO_mem_addr = ADDR_UART_STAT;
    resetn = 1'b0;
    #1;
    chk("midframe_reset_tx", 32'(uart_tx), 32'd1);
    chk("midframe_reset_status", bus.IO_mem_rdata, 32'h0);
    chk("midframe_reset_leds", 32'(leds), 32'h0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    repeat (2) @(negedge clk);
    bus_write(ADDR_UART_DATA, 32'hC3, p);
    expect_frame(8'hC3, p + LAT);
    idle_to(p + 100 + LAT + 3);

    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL frames_outstanding: got %0d unsent frames, expected 0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
